// File: rtl/instr_fetch_unit_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : instr_fetch_unit_if                                           |
// | Purpose  : Bundles the fetch unit's memory request/response channel,     |
// |            the redirect input and the decode-side instruction channel.   |
// | Modports : master - the fetch unit (drives requests and instructions)    |
// |            slave  - the environment (memory, branch unit, decode)        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface instr_fetch_unit_if;
  // instruction memory request channel
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  // instruction memory response channel (in request order)
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  // taken branch / jump
  logic        redirect;
  logic [31:0] redirect_pc;
  // decode channel
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [6:0]  op_code;
  logic [2:0]  funct3;
  logic [6:0]  funct7;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid, imem_rsp_data,
    input  redirect, redirect_pc,
    output inst_valid, inst, inst_pc, op_code, funct3, funct7,
    input  inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid, imem_rsp_data,
    output redirect, redirect_pc,
    input  inst_valid, inst, inst_pc, op_code, funct3, funct7,
    output inst_ready
  );
endinterface
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : instr_fetch_unit                                              |
// | Purpose  : Owns the fetch PC, issues in-order instruction reads, buffers |
// |            returned words with their PCs and presents them to decode    |
// |            with op_code/funct3/funct7 pre-split. A redirect flushes the |
// |            buffer and discards every response still in flight.         |
// | Ports    : clk   - rising-edge clock                                     |
// |            rst_n - asynchronous active-low reset                         |
// |            bus   - instr_fetch_unit_if.master (memory, redirect, decode) |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  wire logic                 clk,
  input  wire logic                 rst_n,
  instr_fetch_unit_if.master        bus
);

  localparam int          AW    = $clog2(DEPTH);
  localparam int          CW    = AW + 1;
  localparam int          UW    = CW + 2;
  localparam logic [31:0] C_NOP = 32'h0000_0013;

  // instruction buffer: word + pc per entry
  logic [31:0]   word_q [DEPTH];
  logic [31:0]   wpc_q  [DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q, count_d;
  // pcs of outstanding (non-discarded) requests, oldest at the head
  logic [31:0]   pcq_q  [DEPTH];
  logic [AW-1:0] pcq_rd_q, pcq_wr_q;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] out_cnt_q, out_cnt_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;

  logic          w_pop, w_push, w_rsp_drop, w_req_valid, w_accept;
  logic [UW-1:0] w_used;

  assign w_pop      = bus.inst_valid && bus.inst_ready;
  assign w_push     = bus.imem_rsp_valid && (drop_cnt_q == '0);
  assign w_rsp_drop = bus.imem_rsp_valid && (drop_cnt_q != '0);

  // Every request holds a credit until its word leaves the buffer or its
  // discard completes; a same-cycle pop frees one credit early.
  assign w_used = UW'(count_q) + UW'(out_cnt_q) + UW'(drop_cnt_q) - UW'(w_pop);

  // rst_n gates the request so it drops immediately on async reset.
  assign w_req_valid = rst_n && !bus.redirect && (w_used < UW'(DEPTH));
  assign w_accept    = w_req_valid && bus.imem_req_ready;

  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_req_addr  = fetch_pc_q;
  assign bus.inst_valid     = (count_q != '0);
  assign bus.inst           = word_q[rd_ptr_q];
  assign bus.inst_pc        = wpc_q[rd_ptr_q];
  assign bus.op_code        = word_q[rd_ptr_q][6:0];
  assign bus.funct3         = word_q[rd_ptr_q][14:12];
  assign bus.funct7         = word_q[rd_ptr_q][31:25];

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    count_d    = count_q;
    out_cnt_d  = out_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (bus.redirect) begin
      fetch_pc_d = bus.redirect_pc & 32'hFFFF_FFFC;
      count_d    = '0;
      out_cnt_d  = '0;
      // Whatever is still in flight after this cycle's response is stale.
      drop_cnt_d = drop_cnt_q - CW'(w_rsp_drop) + out_cnt_q - CW'(w_push);
    end else begin
      if (w_accept) fetch_pc_d = fetch_pc_q + 32'd4;
      count_d    = count_q + CW'(w_push) - CW'(w_pop);
      out_cnt_d  = out_cnt_q + CW'(w_accept) - CW'(w_push);
      drop_cnt_d = drop_cnt_q - CW'(w_rsp_drop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      count_q    <= '0;
      out_cnt_q  <= '0;
      drop_cnt_q <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      pcq_rd_q   <= '0;
      pcq_wr_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        word_q[i] <= C_NOP;
        wpc_q[i]  <= '0;
        pcq_q[i]  <= '0;
      end
    end else begin
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      out_cnt_q  <= out_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      if (bus.redirect) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        pcq_rd_q <= '0;
        pcq_wr_q <= '0;
      end else begin
        if (w_accept) begin
          pcq_q[pcq_wr_q] <= fetch_pc_q;
          pcq_wr_q        <= pcq_wr_q + AW'(1);
        end
        // A response never arrives in its own accept cycle, so the pc queue
        // head is always valid (and not being written) when a push happens.
        if (w_push) begin
          word_q[wr_ptr_q] <= bus.imem_rsp_data;
          wpc_q[wr_ptr_q]  <= pcq_q[pcq_rd_q];
          wr_ptr_q         <= wr_ptr_q + AW'(1);
          pcq_rd_q         <= pcq_rd_q + AW'(1);
        end
        if (w_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_instr_fetch_unit                                           |
// | Purpose  : Self-checking bench for instr_fetch_unit: directed vector     |
// |            table, hand-written corner sequences and a randomized run    |
// |            against a queue-based reference model.                       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_instr_fetch_unit;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] C_NOP    = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_fetch_unit_if bus();

  instr_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // reference model: in-flight requests (oldest first) and buffered pcs
  typedef struct {
    logic [31:0] addr;
    logic        stale;
    int          due;
  } req_t;

  typedef struct {
    bit          ir;
    bit          rd;
    logic [31:0] rpc;
    bit          e_rv;
    logic [31:0] e_addr;
    bit          e_iv;
    logic [31:0] e_pc;
  } vec_t;

  req_t        mem_q[$];
  logic [31:0] buf_q[$];
  logic [31:0] exp_addr;
  int          cyc;
  int          lat_min, lat_max;
  int          n_chk = 0;
  int          n_fail = 0;
  vec_t        tbl[12];

  // memory contents; address 0 holds 32'h4020_8133
  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h4020_8133;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    mem_q.delete();
    buf_q.delete();
    exp_addr = RESET_PC;
    cyc      = 0;
  endtask

  // One clock cycle: drive inputs, let memory respond, check outputs
  // against the model, then advance the model.
  task automatic step(input bit rdy, input bit ir, input bit rd, input logic [31:0] rpc);
    bit          rsp, pop_m, rv_m;
    req_t        h;
    logic [31:0] w;
    @(negedge clk);
    bus.imem_req_ready = rdy;
    bus.inst_ready     = ir;
    bus.redirect       = rd;
    bus.redirect_pc    = rpc;
    rsp = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    bus.imem_rsp_valid = rsp;
    bus.imem_rsp_data  = rsp ? memf(mem_q[0].addr) : $urandom;
    #1;
    pop_m = (buf_q.size() > 0) && ir;
    rv_m  = !rd && ((buf_q.size() + mem_q.size() - int'(pop_m)) < DEPTH);
    chk("inst_valid", 32'(bus.inst_valid), 32'(buf_q.size() > 0));
    chk("req_valid", 32'(bus.imem_req_valid), 32'(rv_m));
    if (rv_m) chk("req_addr", bus.imem_req_addr, exp_addr);
    if (buf_q.size() > 0) begin
      w = memf(buf_q[0]);
      chk("inst_pc", bus.inst_pc, buf_q[0]);
      chk("inst", bus.inst, w);
      chk("op_code", 32'(bus.op_code), 32'(w[6:0]));
      chk("funct3", 32'(bus.funct3), 32'(w[14:12]));
      chk("funct7", 32'(bus.funct7), 32'(w[31:25]));
    end
    if (rsp) h = mem_q.pop_front();
    if (rd) begin
      foreach (mem_q[i]) mem_q[i].stale = 1'b1;
      buf_q.delete();
      exp_addr = rpc & 32'hFFFF_FFFC;
    end else begin
      if (pop_m) void'(buf_q.pop_front());
      if (rsp && !h.stale) buf_q.push_back(h.addr);
      if (rv_m && rdy) begin
        mem_q.push_back('{exp_addr, 1'b0, cyc + int'($urandom_range(lat_max, lat_min))});
        exp_addr = exp_addr + 32'd4;
      end
    end
    cyc++;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_valid"}, 32'(bus.imem_req_valid), 32'd0);
    chk({tag, "_req_addr"}, bus.imem_req_addr, RESET_PC);
    chk({tag, "_inst_valid"}, 32'(bus.inst_valid), 32'd0);
    chk({tag, "_inst"}, bus.inst, C_NOP);
    chk({tag, "_inst_pc"}, bus.inst_pc, 32'd0);
    chk({tag, "_op_code"}, 32'(bus.op_code), 32'h13);
  endtask

  task automatic idle_inputs();
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.redirect       = 1'b0;
    bus.redirect_pc    = '0;
    bus.inst_ready     = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit found;
    // 1-cycle memory, always ready: {ir, rd, rpc, req_valid, req_addr, inst_valid, inst_pc}
    tbl[0]  = '{1, 0, 32'h0,   1, 32'h000, 0, 32'h0};
    tbl[1]  = '{1, 0, 32'h0,   1, 32'h004, 0, 32'h0};
    tbl[2]  = '{1, 0, 32'h0,   1, 32'h008, 1, 32'h000};
    tbl[3]  = '{0, 0, 32'h0,   0, 32'h0,   1, 32'h004};
    tbl[4]  = '{0, 0, 32'h0,   0, 32'h0,   1, 32'h004};
    tbl[5]  = '{0, 0, 32'h0,   0, 32'h0,   1, 32'h004};
    tbl[6]  = '{1, 0, 32'h0,   1, 32'h00C, 1, 32'h004};
    tbl[7]  = '{1, 0, 32'h0,   1, 32'h010, 1, 32'h008};
    tbl[8]  = '{1, 1, 32'h102, 0, 32'h0,   1, 32'h00C};
    tbl[9]  = '{1, 0, 32'h0,   1, 32'h100, 0, 32'h0};
    tbl[10] = '{1, 0, 32'h0,   1, 32'h104, 0, 32'h0};
    tbl[11] = '{1, 0, 32'h0,   1, 32'h108, 1, 32'h100};

    idle_inputs();
    model_reset();
    lat_min = 1;
    lat_max = 1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(posedge clk);
    #2 rst_n = 1'b1;

    // directed table
    for (int i = 0; i < 12; i++) begin
      step(1'b1, tbl[i].ir, tbl[i].rd, tbl[i].rpc);
      chk($sformatf("tbl%0d_req_valid", i), 32'(bus.imem_req_valid), 32'(tbl[i].e_rv));
      if (tbl[i].e_rv) chk($sformatf("tbl%0d_req_addr", i), bus.imem_req_addr, tbl[i].e_addr);
      chk($sformatf("tbl%0d_inst_valid", i), 32'(bus.inst_valid), 32'(tbl[i].e_iv));
      if (tbl[i].e_iv) chk($sformatf("tbl%0d_inst_pc", i), bus.inst_pc, tbl[i].e_pc);
      if (i == 2) begin
        chk("split_op_code", 32'(bus.op_code), 32'h33);
        chk("split_funct3", 32'(bus.funct3), 32'h0);
        chk("split_funct7", 32'(bus.funct7), 32'h20);
      end
    end

    // redirect to 0x102 with two responses still pending
    repeat (4) step(1'b0, 1'b1, 1'b0, 32'h0);
    lat_min = 4;
    lat_max = 4;
    repeat (3) step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b1, 32'h0000_0102);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      if (bus.inst_valid) begin
        found = 1'b1;
        chk("redirect_first_pc", bus.inst_pc, 32'h0000_0100);
      end
    end
    if (!found) begin
      n_chk++;
      n_fail++;
      $display("FAIL redirect_first_pc: got no instruction expected pc 00000100 within 20 cycles");
    end

    // fetch pc wrap-around
    lat_min = 1;
    lat_max = 1;
    step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF9);
    repeat (8) step(1'b1, 1'b1, 1'b0, 32'h0);

    // async reset with the buffer full
    repeat (4) step(1'b1, 1'b0, 1'b0, 32'h0);
    @(posedge clk);
    #2;
    idle_inputs();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    model_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (6) step(1'b1, 1'b1, 1'b0, 32'h0);

    // randomized run
    lat_min = 1;
    lat_max = 4;
    for (int k = 0; k < 3000; k++) begin
      step($urandom_range(3, 0) != 0, $urandom_range(9, 0) < 7,
           $urandom_range(31, 0) == 0, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
